// File: rtl/micro_control_store_if.sv
// Bus between the micro-sequencer dispatch mux / memory side and the control store.
// The mux side drives the micro-address and memory handshake; the store drives sequencing and datapath controls.
interface micro_control_store_if #(
   parameter int CNT_W = 16
);
   logic [3:0]       upc;
   logic             mem_ready;
   logic [1:0]       next;
   logic [3:0]       mpc;
   logic             mem_req;
   logic             pc_write;
   logic             pc_write_cond;
   logic             ior_d;
   logic             mem_read;
   logic             mem_write;
   logic             ir_write;
   logic             mem_to_reg;
   logic             reg_dst;
   logic             reg_write;
   logic             alu_src_a;
   logic [1:0]       alu_src_b;
   logic [1:0]       alu_op;
   logic [1:0]       pc_src;
   logic [CNT_W-1:0] instr_count;
   logic             err_illegal;
   logic             err_timeout;

   modport master (
      output upc, mem_ready,
      input  next, mpc, mem_req, pc_write, pc_write_cond, ior_d, mem_read, mem_write,
             ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_src, instr_count, err_illegal, err_timeout
   );

   modport slave (
      input  upc, mem_ready,
      output next, mpc, mem_req, pc_write, pc_write_cond, ior_d, mem_read, mem_write,
             ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_src, instr_count, err_illegal, err_timeout
   );
endinterface

// File: rtl/micro_control_store.sv
// Microprogram control store for the multicycle MIPS micro-controller: decodes the micro-address,
// closes the sequencer loop, and handles memory wait states, boot, retirement counting and error flags.
module micro_control_store #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input  logic                  clock,
   input  logic                  reset_n,
   micro_control_store_if.slave  bus
);

   localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   typedef enum logic {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } boot_state_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       ior_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_src;
   } ctl_t;

   boot_state_t       state_r;
   boot_state_t       state_nxt_s;
   logic              running_s;

   ctl_t              tbl_ctl_s;
   logic [1:0]        tbl_next_s;
   logic              tbl_mem_s;
   logic              tbl_illegal_s;
   logic              tbl_retire_s;

   logic              stall_s;
   logic              timeout_s;
   logic              retire_s;

   ctl_t              ctl_s;
   logic [1:0]        next_s;
   logic [3:0]        mpc_s;
   logic              mem_req_s;

   logic [WAIT_W-1:0] wait_r;
   logic [CNT_W-1:0]  instr_count_r;
   logic              err_illegal_r;
   logic              err_timeout_r;

   // Boot state register: leaves BOOT on the first edge after reset release.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_BOOT;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Boot next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_BOOT: state_nxt_s = ST_RUN;
         ST_RUN:  state_nxt_s = ST_RUN;
         default: state_nxt_s = ST_BOOT;
      endcase
   end

   assign running_s = (state_r == ST_RUN);

   // Control store table: raw per-state controls before stall/timeout modification.
   always_comb begin
      tbl_ctl_s     = '0;
      tbl_next_s    = 2'b00;
      tbl_mem_s     = 1'b0;
      tbl_illegal_s = 1'b0;
      tbl_retire_s  = 1'b0;
      case (bus.upc)
         4'd0: begin
            tbl_ctl_s.mem_read  = 1'b1;
            tbl_ctl_s.ir_write  = 1'b1;
            tbl_ctl_s.pc_write  = 1'b1;
            tbl_ctl_s.alu_src_b = 2'b01;
            tbl_mem_s           = 1'b1;
            tbl_next_s          = 2'b11;
         end
         4'd1: begin
            tbl_ctl_s.alu_src_b = 2'b11;
            tbl_next_s          = 2'b01;
         end
         4'd2: begin
            tbl_ctl_s.alu_src_a = 1'b1;
            tbl_ctl_s.alu_src_b = 2'b10;
            tbl_next_s          = 2'b10;
         end
         4'd3: begin
            tbl_ctl_s.mem_read = 1'b1;
            tbl_ctl_s.ior_d    = 1'b1;
            tbl_mem_s          = 1'b1;
            tbl_next_s         = 2'b11;
         end
         4'd4: begin
            tbl_ctl_s.reg_write  = 1'b1;
            tbl_ctl_s.mem_to_reg = 1'b1;
            tbl_next_s           = 2'b00;
            tbl_retire_s         = 1'b1;
         end
         4'd5: begin
            tbl_ctl_s.mem_write = 1'b1;
            tbl_ctl_s.ior_d     = 1'b1;
            tbl_mem_s           = 1'b1;
            tbl_next_s          = 2'b00;
            tbl_retire_s        = bus.mem_ready;
         end
         4'd6: begin
            tbl_ctl_s.alu_src_a = 1'b1;
            tbl_ctl_s.alu_op    = 2'b10;
            tbl_next_s          = 2'b11;
         end
         4'd7: begin
            tbl_ctl_s.reg_dst   = 1'b1;
            tbl_ctl_s.reg_write = 1'b1;
            tbl_next_s          = 2'b00;
            tbl_retire_s        = 1'b1;
         end
         4'd8: begin
            tbl_ctl_s.alu_src_a     = 1'b1;
            tbl_ctl_s.alu_op        = 2'b01;
            tbl_ctl_s.pc_write_cond = 1'b1;
            tbl_ctl_s.pc_src        = 2'b01;
            tbl_next_s              = 2'b00;
            tbl_retire_s            = 1'b1;
         end
         4'd9: begin
            tbl_ctl_s.pc_write = 1'b1;
            tbl_ctl_s.pc_src   = 2'b10;
            tbl_next_s         = 2'b00;
            tbl_retire_s       = 1'b1;
         end
         default: begin
            tbl_illegal_s = 1'b1;
         end
      endcase
   end

   // A timeout replaces the final stall cycle, so the two are mutually exclusive.
   assign timeout_s = running_s && tbl_mem_s && !bus.mem_ready && (wait_r == WAIT_LAST);
   assign stall_s   = running_s && tbl_mem_s && !bus.mem_ready && !timeout_s;
   assign retire_s  = running_s && tbl_retire_s;

   // Output shaping: boot forces a fetch of address 0; stalls re-issue the same upc via mpc+1.
   always_comb begin
      ctl_s     = '0;
      next_s    = 2'b00;
      mpc_s     = 4'd0;
      mem_req_s = 1'b0;
      if (!running_s) begin
         ctl_s     = '0;
         next_s    = 2'b00;
         mpc_s     = 4'd0;
         mem_req_s = 1'b0;
      end else if (timeout_s) begin
         ctl_s     = '0;
         next_s    = 2'b00;
         mpc_s     = bus.upc;
         mem_req_s = 1'b1;
      end else if (stall_s) begin
         ctl_s          = tbl_ctl_s;
         ctl_s.ir_write = 1'b0;
         ctl_s.pc_write = 1'b0;
         next_s         = 2'b11;
         mpc_s          = bus.upc - 4'd1;
         mem_req_s      = 1'b1;
      end else begin
         ctl_s     = tbl_ctl_s;
         next_s    = tbl_next_s;
         mpc_s     = bus.upc;
         mem_req_s = tbl_mem_s;
      end
   end

   // Wait-state counter: counts stalled cycles of the current memory access.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wait_r <= '0;
      end else if (stall_s) begin
         wait_r <= wait_r + WAIT_W'(1);
      end else begin
         wait_r <= '0;
      end
   end

   // Retired-instruction counter, wrapping naturally at its width.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         instr_count_r <= '0;
      end else if (retire_s) begin
         instr_count_r <= instr_count_r + CNT_W'(1);
      end else begin
         instr_count_r <= instr_count_r;
      end
   end

   // Sticky error flags, cleared only by reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         err_illegal_r <= 1'b0;
         err_timeout_r <= 1'b0;
      end else begin
         err_illegal_r <= err_illegal_r | (running_s & tbl_illegal_s);
         err_timeout_r <= err_timeout_r | timeout_s;
      end
   end

   assign bus.next          = next_s;
   assign bus.mpc           = mpc_s;
   assign bus.mem_req       = mem_req_s;
   assign bus.pc_write      = ctl_s.pc_write;
   assign bus.pc_write_cond = ctl_s.pc_write_cond;
   assign bus.ior_d         = ctl_s.ior_d;
   assign bus.mem_read      = ctl_s.mem_read;
   assign bus.mem_write     = ctl_s.mem_write;
   assign bus.ir_write      = ctl_s.ir_write;
   assign bus.mem_to_reg    = ctl_s.mem_to_reg;
   assign bus.reg_dst       = ctl_s.reg_dst;
   assign bus.reg_write     = ctl_s.reg_write;
   assign bus.alu_src_a     = ctl_s.alu_src_a;
   assign bus.alu_src_b     = ctl_s.alu_src_b;
   assign bus.alu_op        = ctl_s.alu_op;
   assign bus.pc_src        = ctl_s.pc_src;
   assign bus.instr_count   = instr_count_r;
   assign bus.err_illegal   = err_illegal_r;
   assign bus.err_timeout   = err_timeout_r;

endmodule

// File: tb/tb_micro_control_store.sv
// Directed bench for micro_control_store: a table-driven model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_micro_control_store;
   localparam int TIMEOUT = 16;
   localparam int CNT_W   = 16;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   logic check_en = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   micro_control_store_if #(.CNT_W(CNT_W)) bus ();

   micro_control_store #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   // Control word order: pc_write pc_write_cond ior_d mem_read mem_write ir_write mem_to_reg
   // reg_dst reg_write alu_src_a alu_src_b[2] alu_op[2] pc_src[2]
   logic [15:0] tbl_ctl [16];
   logic [1:0]  tbl_next [16];

   logic [15:0] dut_ctl;
   assign dut_ctl = {bus.pc_write, bus.pc_write_cond, bus.ior_d, bus.mem_read, bus.mem_write,
                     bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                     bus.alu_src_b, bus.alu_op, bus.pc_src};

   logic             m_booted;
   int               m_wait;
   logic [CNT_W-1:0] m_cnt;
   logic             m_ill;
   logic             m_to;

   function automatic bit is_mem(input logic [3:0] u);
      return (u == 4'd0) || (u == 4'd3) || (u == 4'd5);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference behaviour advanced on each clock edge.
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_booted <= 1'b0;
         m_wait   <= 0;
         m_cnt    <= '0;
         m_ill    <= 1'b0;
         m_to     <= 1'b0;
      end else begin
         m_booted <= 1'b1;
         if (m_booted) begin
            if (is_mem(bus.upc) && !bus.mem_ready) begin
               if (m_wait == TIMEOUT - 1) begin
                  m_wait <= 0;
                  m_to   <= 1'b1;
               end else begin
                  m_wait <= m_wait + 1;
               end
            end else begin
               m_wait <= 0;
            end
            if (bus.upc >= 4'd10) m_ill <= 1'b1;
            if (bus.upc == 4'd4 || bus.upc == 4'd7 || bus.upc == 4'd8 || bus.upc == 4'd9 ||
                (bus.upc == 4'd5 && bus.mem_ready))
               m_cnt <= m_cnt + 1'b1;
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clock) begin
      logic [15:0] e_ctl;
      logic [1:0]  e_next;
      logic [3:0]  e_mpc;
      logic        e_req;
      if (check_en) begin
         e_ctl = 16'h0000; e_next = 2'b00; e_mpc = 4'd0; e_req = 1'b0;
         if (m_booted) begin
            e_req = is_mem(bus.upc);
            if (is_mem(bus.upc) && !bus.mem_ready && m_wait == TIMEOUT - 1) begin
               e_mpc = bus.upc;
            end else if (is_mem(bus.upc) && !bus.mem_ready) begin
               e_ctl  = tbl_ctl[bus.upc] & 16'h7BFF;
               e_next = 2'b11;
               e_mpc  = bus.upc - 4'd1;
            end else begin
               e_ctl  = tbl_ctl[bus.upc];
               e_next = tbl_next[bus.upc];
               e_mpc  = bus.upc;
            end
         end
         check("next", 32'(bus.next), 32'(e_next));
         check("mpc", 32'(bus.mpc), 32'(e_mpc));
         check("mem_req", 32'(bus.mem_req), 32'(e_req));
         check("controls", 32'(dut_ctl), 32'(e_ctl));
         check("instr_count", 32'(bus.instr_count), 32'(m_cnt));
         check("err_illegal", 32'(bus.err_illegal), 32'(m_ill));
         check("err_timeout", 32'(bus.err_timeout), 32'(m_to));
      end
   end

   task automatic drive(input logic [3:0] u, input logic r);
      @(posedge clock);
      #1;
      bus.upc       = u;
      bus.mem_ready = r;
      @(negedge clock);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         tbl_ctl[i]  = 16'h0000;
         tbl_next[i] = 2'b00;
      end
      tbl_ctl[0] = 16'h9410; tbl_next[0] = 2'b11;
      tbl_ctl[1] = 16'h0030; tbl_next[1] = 2'b01;
      tbl_ctl[2] = 16'h0060; tbl_next[2] = 2'b10;
      tbl_ctl[3] = 16'h3000; tbl_next[3] = 2'b11;
      tbl_ctl[4] = 16'h0280; tbl_next[4] = 2'b00;
      tbl_ctl[5] = 16'h2800; tbl_next[5] = 2'b00;
      tbl_ctl[6] = 16'h0048; tbl_next[6] = 2'b11;
      tbl_ctl[7] = 16'h0180; tbl_next[7] = 2'b00;
      tbl_ctl[8] = 16'h4045; tbl_next[8] = 2'b00;
      tbl_ctl[9] = 16'h8002; tbl_next[9] = 2'b00;

      bus.upc       = 4'd12;
      bus.mem_ready = 1'b0;
      reset_n       = 1'b0;
      repeat (2) @(posedge clock);
      check_en = 1'b1;

      // Boot cycle: illegal upc must be ignored
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      @(negedge clock);
      #1;
      check("boot_next", 32'(bus.next), 32'd0);
      check("boot_mpc", 32'(bus.mpc), 32'd0);
      check("boot_ctl", 32'(dut_ctl), 32'd0);

      drive(4'd0, 1'b1);
      check("fetch_ctl", 32'(dut_ctl), 32'h9410);
      check("fetch_next", 32'(bus.next), 32'd3);
      check("boot_no_illegal", 32'(bus.err_illegal), 32'd0);

      // R-type, mem_ready ignored in non-memory states
      drive(4'd1, 1'b0);
      drive(4'd6, 1'b1);
      drive(4'd7, 1'b0);
      check("rtype_wb", 32'({bus.reg_dst, bus.reg_write}), 32'd3);
      drive(4'd0, 1'b1);
      check("rtype_count", 32'(bus.instr_count), 32'd1);

      // LW with three wait states
      drive(4'd1, 1'b1);
      drive(4'd2, 1'b1);
      for (int i = 0; i < 3; i++) begin
         drive(4'd3, 1'b0);
         check("lw_stall_mpc", 32'(bus.mpc), 32'd2);
         check("lw_stall_rd", 32'({bus.next, bus.mem_read}), 32'h7);
      end
      drive(4'd3, 1'b1);
      drive(4'd4, 1'b0);
      check("lw_wb", 32'({bus.reg_write, bus.mem_to_reg}), 32'd3);

      // Fetch stall
      for (int i = 0; i < 2; i++) begin
         drive(4'd0, 1'b0);
         check("fetch_stall_mpc", 32'(bus.mpc), 32'd15);
         check("fetch_stall_gate", 32'({bus.ir_write, bus.pc_write}), 32'd0);
      end
      drive(4'd0, 1'b1);
      check("lw_count", 32'(bus.instr_count), 32'd2);
      check("fetch_done", 32'({bus.ir_write, bus.pc_write}), 32'd3);

      // SW timeout
      drive(4'd1, 1'b1);
      drive(4'd2, 1'b1);
      for (int i = 0; i < TIMEOUT - 1; i++) drive(4'd5, 1'b0);
      check("pre_timeout_next", 32'(bus.next), 32'd3);
      drive(4'd5, 1'b0);
      check("timeout_next", 32'(bus.next), 32'd0);
      check("timeout_ctl", 32'({bus.mem_req, dut_ctl}), 32'h10000);
      drive(4'd0, 1'b1);
      check("timeout_flag", 32'(bus.err_timeout), 32'd1);
      check("timeout_no_retire", 32'(bus.instr_count), 32'd2);
      check("post_timeout_fetch", 32'(dut_ctl), 32'h9410);

      // SW completing after one wait, then branch and jump
      drive(4'd1, 1'b1);
      drive(4'd2, 1'b1);
      drive(4'd5, 1'b0);
      drive(4'd5, 1'b1);
      drive(4'd8, 1'b1);
      drive(4'd9, 1'b1);
      drive(4'd0, 1'b1);
      check("sw_br_j_count", 32'(bus.instr_count), 32'd5);

      // Illegal state
      drive(4'd12, 1'b1);
      check("illegal_next", 32'({bus.next, dut_ctl}), 32'd0);
      drive(4'd0, 1'b1);
      check("illegal_flag", 32'(bus.err_illegal), 32'd1);
      drive(4'd1, 1'b1);
      check("illegal_sticky", 32'(bus.err_illegal), 32'd1);

      // Asynchronous reset in the middle of a stall
      drive(4'd2, 1'b1);
      drive(4'd3, 1'b0);
      drive(4'd3, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst_flags", 32'({bus.err_illegal, bus.err_timeout}), 32'd0);
      check("async_rst_count", 32'(bus.instr_count), 32'd0);
      check("async_rst_req", 32'(bus.mem_req), 32'd0);
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      bus.upc = 4'd3;
      bus.mem_ready = 1'b0;
      @(negedge clock);
      #1;
      check("reboot_next", 32'({bus.next, bus.mpc}), 32'd0);
      drive(4'd0, 1'b1);
      check("reboot_fetch", 32'(dut_ctl), 32'h9410);
      drive(4'd1, 1'b1);
      drive(4'd6, 1'b1);
      drive(4'd7, 1'b1);
      drive(4'd0, 1'b1);
      check("reboot_count", 32'(bus.instr_count), 32'd1);

      @(posedge clock);
      check_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
